// File: rtl/trig_route_pkg.sv
// trig_route_pkg: shared encodings and helpers for the trigger router.
// Holds mode encodings, the pulse FSM state enum and a saturating increment.
package trig_route_pkg;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'b00,
        MODE_EDGE    = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_OFF     = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_DELAY = 2'b01,
        ST_PULSE = 2'b10
    } state_e;

    // Increment that sticks at lim instead of wrapping.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input logic [31:0] lim
    );
        return (v >= lim) ? lim : v + 32'd1;
    endfunction

endpackage

// File: rtl/trig_route_ctrl_pulse.sv
// trig_pulse_gen: delay/width pulse FSM with down-counters.
// Ports: i_fire starts a pulse from IDLE, i_abort forces IDLE, i_delay/i_width
// are captured on fire; o_pulse is high in PULSE, o_busy in DELAY or PULSE.
module trig_pulse_gen
    import trig_route_pkg::*;
#(
    parameter int DLY_W = 16,
    parameter int WID_W = 16
) (
    input  logic             ext_clock,
    input  logic             resetn,
    input  logic             i_fire,
    input  logic             i_abort,
    input  logic [DLY_W-1:0] i_delay,
    input  logic [WID_W-1:0] i_width,
    output logic             o_pulse,
    output logic             o_busy
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [DLY_W-1:0] r_dcnt;
    logic [DLY_W-1:0] w_dcnt_nxt;
    logic [WID_W-1:0] r_wcnt;
    logic [WID_W-1:0] w_wcnt_nxt;
    logic [WID_W-1:0] r_wid;
    logic [WID_W-1:0] w_wid_nxt;

    // Width 0 behaves as 1: the count holds remaining cycles after this one.
    function automatic logic [WID_W-1:0] wid_load(input logic [WID_W-1:0] w);
        return (w == '0) ? '0 : w - WID_W'(1);
    endfunction

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_wcnt_nxt  = r_wcnt;
        w_wid_nxt   = r_wid;
        unique case (r_state)
            ST_IDLE: begin
                if (i_fire) begin
                    w_wid_nxt = i_width;
                    if (i_delay == '0) begin
                        w_state_nxt = ST_PULSE;
                        w_wcnt_nxt  = wid_load(i_width);
                    end else begin
                        w_state_nxt = ST_DELAY;
                        w_dcnt_nxt  = i_delay - DLY_W'(1);
                    end
                end
            end
            ST_DELAY: begin
                if (r_dcnt == '0) begin
                    w_state_nxt = ST_PULSE;
                    w_wcnt_nxt  = wid_load(r_wid);
                end else begin
                    w_dcnt_nxt = r_dcnt - DLY_W'(1);
                end
            end
            ST_PULSE: begin
                if (r_wcnt == '0) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wcnt_nxt = r_wcnt - WID_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (i_abort) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
            r_dcnt  <= '0;
            r_wcnt  <= '0;
            r_wid   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_dcnt  <= w_dcnt_nxt;
            r_wcnt  <= w_wcnt_nxt;
            r_wid   <= w_wid_nxt;
        end
    end

    assign o_pulse = (r_state == ST_PULSE);
    assign o_busy  = (r_state != ST_IDLE);

endmodule

// File: rtl/trig_route_ctrl.sv
// trig_route_ctrl: capture-trigger router/shaper plus heartbeat LED counter.
// Ports: src_trig/cfg_sel pick a source, cfg_mode/cfg_delay/cfg_width/arm
// shape it; outputs trig_out, busy, armed, trig_count, led_heartbeat, and
// ts_out when TRIG_ROUTE_TIMESTAMP_EN is defined.
module trig_route_ctrl
    import trig_route_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int SEL_W = 2,
    parameter int DLY_W = 16,
    parameter int WID_W = 16,
    parameter int CNT_W = 16,
    parameter int HB_W  = 23,
    parameter int TS_W  = 32
) (
    input  logic             ext_clock,
    input  logic             resetn,
    input  logic [N_SRC-1:0] src_trig,
    input  logic [SEL_W-1:0] cfg_sel,
    input  logic [1:0]       cfg_mode,
    input  logic [DLY_W-1:0] cfg_delay,
    input  logic [WID_W-1:0] cfg_width,
    input  logic             arm,
    output logic             trig_out,
    output logic             busy,
    output logic             armed,
    output logic [CNT_W-1:0] trig_count,
    output logic             led_heartbeat
`ifdef TRIG_ROUTE_TIMESTAMP_EN
    ,
    output logic [TS_W-1:0]  ts_out
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    mode_e            w_mode;
    logic             w_src;
    logic             w_rise;
    logic             w_fire;
    logic             w_abort;
    logic             w_pulse;
    logic             w_busy;
    logic             w_trig_rise;
    logic             r_src_prev;
    logic             r_pass;
    logic             r_trig_prev;
    logic             r_armed;
    logic [CNT_W-1:0] r_count;
    logic [HB_W-1:0]  r_hb;

    assign w_mode = mode_e'(cfg_mode);

    // Out-of-range selects match no channel and read as 0.
    always_comb begin
        w_src = 1'b0;
        for (int i = 0; i < N_SRC; i++) begin
            if (cfg_sel == SEL_W'(i)) begin
                w_src = src_trig[i];
            end
        end
    end

    assign w_rise = w_src & ~r_src_prev;

    // An arm in the same cycle as the edge wins: the edge is dropped.
    always_comb begin
        w_fire = 1'b0;
        if (w_rise && !w_busy) begin
            if (w_mode == MODE_EDGE) begin
                w_fire = 1'b1;
            end else if (w_mode == MODE_ONESHOT) begin
                w_fire = r_armed & ~arm;
            end
        end
    end

    assign w_abort = (w_mode == MODE_OFF);

    trig_pulse_gen #(
        .DLY_W (DLY_W),
        .WID_W (WID_W)
    ) u_pulse (
        .ext_clock (ext_clock),
        .resetn    (resetn),
        .i_fire    (w_fire),
        .i_abort   (w_abort),
        .i_delay   (cfg_delay),
        .i_width   (cfg_width),
        .o_pulse   (w_pulse),
        .o_busy    (w_busy)
    );

    // A pulse already running finishes even if the mode leaves edge/one-shot.
    always_comb begin
        trig_out = 1'b0;
        if (w_mode == MODE_OFF) begin
            trig_out = 1'b0;
        end else if (w_busy) begin
            trig_out = w_pulse;
        end else if (w_mode == MODE_PASS) begin
            trig_out = r_pass;
        end
    end

    assign w_trig_rise = trig_out & ~r_trig_prev;

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            r_src_prev  <= 1'b0;
            r_pass      <= 1'b0;
            r_trig_prev <= 1'b0;
            r_armed     <= 1'b0;
            r_count     <= '0;
            r_hb        <= '0;
        end else begin
            r_src_prev  <= w_src;
            r_pass      <= w_src;
            r_trig_prev <= trig_out;
            if (arm) begin
                r_armed <= 1'b1;
            end else if (w_fire && w_mode == MODE_ONESHOT) begin
                r_armed <= 1'b0;
            end
            if (w_trig_rise) begin
                r_count <= CNT_W'(sat_inc(32'(r_count), 32'(CNT_MAX)));
            end
            // Heartbeat stalls while the trigger is high to keep capture quiet.
            if (!trig_out) begin
                r_hb <= r_hb + HB_W'(1);
            end
        end
    end

`ifdef TRIG_ROUTE_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;
    logic [TS_W-1:0] r_ts_out;

    always_ff @(posedge ext_clock or negedge resetn) begin
        if (!resetn) begin
            r_ts     <= '0;
            r_ts_out <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
            if (w_trig_rise) begin
                r_ts_out <= r_ts;
            end
        end
    end

    assign ts_out = r_ts_out;
`endif

    assign busy          = w_busy;
    assign armed         = r_armed;
    assign trig_count    = r_count;
    assign led_heartbeat = r_hb[HB_W-1];

endmodule

// File: tb/tb_trig_route_ctrl.sv
// tb_trig_route_ctrl: directed self-checking bench for trig_route_ctrl.
// Small CNT_W/HB_W and a wide cfg_sel expose saturation, wrap and range.
module tb_trig_route_ctrl;

    localparam int N_SRC = 4;
    localparam int SEL_W = 3;
    localparam int DLY_W = 16;
    localparam int WID_W = 16;
    localparam int CNT_W = 2;
    localparam int HB_W  = 4;
    localparam int TS_W  = 32;

    logic             ext_clock = 1'b0;
    logic             resetn;
    logic [N_SRC-1:0] src_trig;
    logic [SEL_W-1:0] cfg_sel;
    logic [1:0]       cfg_mode;
    logic [DLY_W-1:0] cfg_delay;
    logic [WID_W-1:0] cfg_width;
    logic             arm;
    logic             trig_out;
    logic             busy;
    logic             armed;
    logic [CNT_W-1:0] trig_count;
    logic             led_heartbeat;
`ifdef TRIG_ROUTE_TIMESTAMP_EN
    logic [TS_W-1:0]  ts_out;
`endif

    int vec = 0;
    int err = 0;
    logic [HB_W-1:0] hb_m = '0;
    logic [TS_W-1:0] ts_m = '0;

    always #5 ext_clock = ~ext_clock;

    trig_route_ctrl #(
        .N_SRC (N_SRC),
        .SEL_W (SEL_W),
        .DLY_W (DLY_W),
        .WID_W (WID_W),
        .CNT_W (CNT_W),
        .HB_W  (HB_W),
        .TS_W  (TS_W)
    ) dut (
        .ext_clock     (ext_clock),
        .resetn        (resetn),
        .src_trig      (src_trig),
        .cfg_sel       (cfg_sel),
        .cfg_mode      (cfg_mode),
        .cfg_delay     (cfg_delay),
        .cfg_width     (cfg_width),
        .arm           (arm),
        .trig_out      (trig_out),
        .busy          (busy),
        .armed         (armed),
        .trig_count    (trig_count),
        .led_heartbeat (led_heartbeat)
`ifdef TRIG_ROUTE_TIMESTAMP_EN
        ,
        .ts_out        (ts_out)
`endif
    );

    // One clock; the heartbeat/timestamp model advances from pre-edge values.
    task automatic tick();
        logic t;
        logic r;
        @(negedge ext_clock);
        t = trig_out;
        r = resetn;
        @(posedge ext_clock);
        #1;
        if (!r) begin
            hb_m = '0;
            ts_m = '0;
        end else begin
            if (!t) hb_m = hb_m + 1'b1;
            ts_m = ts_m + 1'b1;
        end
    endtask

    task automatic do_reset();
        src_trig  = '0;
        cfg_sel   = '0;
        cfg_mode  = 2'b11;
        cfg_delay = '0;
        cfg_width = '0;
        arm       = 1'b0;
        resetn    = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        cfg_mode = 2'b00;
        cfg_sel  = 3'd1;
        src_trig = 4'b0010;
        repeat (4) tick();
        vec++;
        if (trig_out !== 1'b1) begin
            err++;
            $display("FAIL reset_pre trig_out got %b want 1", trig_out);
        end
        vec++;
        if (trig_count !== 2'd1) begin
            err++;
            $display("FAIL reset_pre count got %0d want 1", trig_count);
        end
        resetn = 1'b0;
        #1;
        vec++;
        if ({trig_out, busy, armed, trig_count, led_heartbeat} !== 6'b0) begin
            err++;
            $display("FAIL reset_async outs got %b want 000000",
                     {trig_out, busy, armed, trig_count, led_heartbeat});
        end
`ifdef TRIG_ROUTE_TIMESTAMP_EN
        vec++;
        if (ts_out !== '0) begin
            err++;
            $display("FAIL reset_ts got %0d want 0", ts_out);
        end
`endif
        src_trig = '0;
        tick();
        tick();
        resetn = 1'b1;
        tick();
        vec++;
        if (trig_count !== 2'd0 || trig_out !== 1'b0) begin
            err++;
            $display("FAIL reset_release count %0d trig %b want 0 0",
                     trig_count, trig_out);
        end
    endtask

    task automatic test_passthrough();
        do_reset();
        cfg_mode = 2'b00;
        cfg_sel  = 3'd2;
        tick();
        tick();
        src_trig = 4'b0100;
        #1;
        vec++;
        if (trig_out !== 1'b0) begin
            err++;
            $display("FAIL pass_lag got %b want 0", trig_out);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 4) src_trig = '0;
            vec++;
            if (trig_out !== 1'b1 || busy !== 1'b0) begin
                err++;
                $display("FAIL pass_high i=%0d trig %b busy %b want 1 0",
                         i, trig_out, busy);
            end
        end
        tick();
        vec++;
        if (trig_out !== 1'b0) begin
            err++;
            $display("FAIL pass_low got %b want 0", trig_out);
        end
        tick();
        vec++;
        if (trig_count !== 2'd1) begin
            err++;
            $display("FAIL pass_count got %0d want 1", trig_count);
        end
    endtask

    task automatic test_edge();
        logic et;
        logic eb;
        do_reset();
        cfg_mode  = 2'b01;
        cfg_sel   = 3'd0;
        cfg_delay = 16'd3;
        cfg_width = 16'd4;
        tick();
        tick();
        src_trig = 4'b0001;
        for (int k = 1; k <= 12; k++) begin
            tick();
            // A second rising edge during DELAY must be ignored.
            if (k == 1) src_trig = 4'b0000;
            if (k == 2) src_trig = 4'b0001;
            et = (k >= 4 && k <= 7);
            eb = (k >= 1 && k <= 7);
            vec++;
            if (trig_out !== et || busy !== eb) begin
                err++;
                $display("FAIL edge k=%0d trig %b busy %b want %b %b",
                         k, trig_out, busy, et, eb);
            end
        end
        vec++;
        if (trig_count !== 2'd1) begin
            err++;
            $display("FAIL edge_count got %0d want 1", trig_count);
        end
    endtask

    task automatic test_zero();
        do_reset();
        cfg_mode  = 2'b01;
        cfg_sel   = 3'd0;
        cfg_delay = 16'd0;
        cfg_width = 16'd0;
        tick();
        tick();
        src_trig = 4'b0001;
        tick();
        vec++;
        if (trig_out !== 1'b1 || busy !== 1'b1) begin
            err++;
            $display("FAIL zero_n1 trig %b busy %b want 1 1", trig_out, busy);
        end
        for (int k = 0; k < 3; k++) begin
            tick();
            vec++;
            if (trig_out !== 1'b0 || busy !== 1'b0) begin
                err++;
                $display("FAIL zero_after k=%0d trig %b busy %b want 0 0",
                         k, trig_out, busy);
            end
        end
        vec++;
        if (trig_count !== 2'd1) begin
            err++;
            $display("FAIL zero_count got %0d want 1", trig_count);
        end
    endtask

    task automatic test_oneshot();
        int hi;
        do_reset();
        cfg_mode  = 2'b10;
        cfg_sel   = 3'd1;
        cfg_delay = 16'd1;
        cfg_width = 16'd2;
        tick();
        tick();
        hi = 0;
        for (int r = 0; r < 2; r++) begin
            src_trig = 4'b0010;
            repeat (3) begin tick(); if (trig_out) hi++; end
            src_trig = 4'b0000;
            repeat (3) begin tick(); if (trig_out) hi++; end
        end
        vec++;
        if (hi != 0 || armed !== 1'b0) begin
            err++;
            $display("FAIL os_unarmed high %0d armed %b want 0 0", hi, armed);
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        vec++;
        if (armed !== 1'b1) begin
            err++;
            $display("FAIL os_arm got %b want 1", armed);
        end
        hi = 0;
        src_trig = 4'b0010;
        tick();
        vec++;
        if (armed !== 1'b0 || busy !== 1'b1) begin
            err++;
            $display("FAIL os_fire armed %b busy %b want 0 1", armed, busy);
        end
        repeat (3) begin tick(); if (trig_out) hi++; end
        src_trig = 4'b0000;
        repeat (3) begin tick(); if (trig_out) hi++; end
        src_trig = 4'b0010;
        repeat (3) begin tick(); if (trig_out) hi++; end
        src_trig = 4'b0000;
        repeat (4) begin tick(); if (trig_out) hi++; end
        vec++;
        if (hi != 2) begin
            err++;
            $display("FAIL os_single high cycles %0d want 2", hi);
        end
        arm = 1'b1;
        src_trig = 4'b0010;
        tick();
        arm = 1'b0;
        vec++;
        if (armed !== 1'b1 || busy !== 1'b0) begin
            err++;
            $display("FAIL os_arm_edge armed %b busy %b want 1 0", armed, busy);
        end
        hi = 0;
        repeat (5) begin tick(); if (trig_out) hi++; end
        vec++;
        if (hi != 0 || armed !== 1'b1) begin
            err++;
            $display("FAIL os_arm_edge_hold high %0d armed %b want 0 1",
                     hi, armed);
        end
    endtask

    task automatic test_abort();
        do_reset();
        cfg_mode  = 2'b01;
        cfg_sel   = 3'd0;
        cfg_delay = 16'd0;
        cfg_width = 16'd10;
        tick();
        tick();
        src_trig = 4'b0001;
        tick();
        tick();
        tick();
        vec++;
        if (trig_out !== 1'b1 || busy !== 1'b1) begin
            err++;
            $display("FAIL abort_pre trig %b busy %b want 1 1", trig_out, busy);
        end
        cfg_mode = 2'b11;
        tick();
        vec++;
        if (trig_out !== 1'b0 || busy !== 1'b0) begin
            err++;
            $display("FAIL abort trig %b busy %b want 0 0", trig_out, busy);
        end
        cfg_mode = 2'b01;
        #1;
        vec++;
        if (trig_out !== 1'b0 || busy !== 1'b0) begin
            err++;
            $display("FAIL abort_idle trig %b busy %b want 0 0", trig_out, busy);
        end
    endtask

    task automatic test_saturation();
        int exp_c;
        do_reset();
        cfg_mode  = 2'b01;
        cfg_sel   = 3'd0;
        cfg_delay = 16'd0;
        cfg_width = 16'd1;
        tick();
        tick();
        for (int i = 0; i < 5; i++) begin
            src_trig = 4'b0001;
            tick();
            src_trig = 4'b0000;
            tick();
            tick();
            exp_c = (i + 1 > 3) ? 3 : i + 1;
            vec++;
            if (trig_count !== CNT_W'(exp_c)) begin
                err++;
                $display("FAIL sat i=%0d count %0d want %0d",
                         i, trig_count, exp_c);
            end
        end
    endtask

    task automatic test_heartbeat();
        int hi;
        int hb_bad;
        logic prev_t;
        logic ts_pend;
        logic [TS_W-1:0] ts_cap;
        do_reset();
        cfg_mode  = 2'b01;
        cfg_sel   = 3'd3;
        cfg_delay = 16'd2;
        cfg_width = 16'd6;
        hi = 0;
        hb_bad = 0;
        prev_t = 1'b0;
        ts_pend = 1'b0;
        ts_cap = '0;
        for (int c = 0; c < 40; c++) begin
            if (c == 5) src_trig = 4'b1000;
            tick();
            if (led_heartbeat !== hb_m[HB_W-1]) begin
                hb_bad++;
                $display("FAIL hb c=%0d led %b want %b",
                         c, led_heartbeat, hb_m[HB_W-1]);
            end
`ifdef TRIG_ROUTE_TIMESTAMP_EN
            if (ts_pend) begin
                vec++;
                if (ts_out !== ts_cap) begin
                    err++;
                    $display("FAIL ts got %0d want %0d", ts_out, ts_cap);
                end
                ts_pend = 1'b0;
            end
            if (trig_out && !prev_t) begin
                ts_cap = ts_m;
                ts_pend = 1'b1;
            end
`endif
            if (trig_out) hi++;
            prev_t = trig_out;
        end
        vec++;
        if (hb_bad != 0) begin
            err++;
            $display("FAIL hb_track bad cycles %0d want 0", hb_bad);
        end
        vec++;
        if (hi != 6) begin
            err++;
            $display("FAIL hb_pulse high cycles %0d want 6", hi);
        end
    endtask

    task automatic test_sel_range();
        int hi;
        do_reset();
        cfg_sel   = 3'd5;
        cfg_delay = 16'd0;
        cfg_width = 16'd1;
        hi = 0;
        for (int m = 0; m < 2; m++) begin
            cfg_mode = (m == 0) ? 2'b01 : 2'b00;
            for (int r = 0; r < 3; r++) begin
                src_trig = 4'b1111;
                repeat (2) begin tick(); if (trig_out || busy) hi++; end
                src_trig = 4'b0000;
                repeat (2) begin tick(); if (trig_out || busy) hi++; end
            end
        end
        vec++;
        if (hi != 0 || trig_count !== 2'd0) begin
            err++;
            $display("FAIL sel_range active %0d count %0d want 0 0",
                     hi, trig_count);
        end
    endtask

    initial begin
        resetn    = 1'b0;
        src_trig  = '0;
        cfg_sel   = '0;
        cfg_mode  = 2'b00;
        cfg_delay = '0;
        cfg_width = '0;
        arm       = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
        test_reset();
        test_passthrough();
        test_edge();
        test_zero();
        test_oneshot();
        test_abort();
        test_saturation();
        test_heartbeat();
        test_sel_range();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
